// File: rtl/prim_prince_descrambler.sv
// prim_prince_descrambler: read-path descrambler for PRINCE-scrambled memory.
// Keystream = PRINCE_enc({k0,k1}, nonce ^ addr); rsp_data = read data ^ keystream.
// One PRINCE round per clock; one word in flight plus one output register.
// Optional macro PRIM_PRINCE_DESCR_CLEAR_EN adds a synchronous clear input clr_i.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; rsp_valid_o/rsp_data_o hold until accepted; request inputs are ignored
// while req_valid_i is low.
`timescale 1ns/1ps
module prim_prince_descrambler #(
    parameter int unsigned AddrWidth      = 16,
    parameter int unsigned NumRoundsHalf  = 5,
    parameter bit          UseOldKeySched = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
`ifdef PRIM_PRINCE_DESCR_CLEAR_EN
    input  logic                 clr_i,
`endif
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [63:0]          req_data_i,
    input  logic [127:0]         key_i,
    input  logic [63:0]          nonce_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [63:0]          rsp_data_o,
    output logic                 busy_o,
    output logic [2:0]           fsm_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FWD  = 3'd1,
        ST_MID  = 3'd2,
        ST_BWD  = 3'd3,
        ST_OUT  = 3'd4
    } fsm_e;

    // Nibble tables, entry i in bits [4*i +: 4]; nibble 0 is the least significant.
    localparam logic [63:0] Sbox     = 64'h4D5E087619CA23FB;
    localparam logic [63:0] SboxInv  = 64'h1CE5046A98DF237B;
    localparam logic [63:0] ShRow    = 64'hFA50B61C72D83E94;
    localparam logic [63:0] ShRowInv = 64'hF258BE147AD0369C;
    localparam logic [3:0]  BwdRcBase = 4'(10 - NumRoundsHalf);
    localparam logic [2:0]  LastRnd   = 3'(NumRoundsHalf);

    function automatic logic [63:0] rc(input logic [3:0] idx);
        logic [63:0] v;
        case (idx)
            4'd1:    v = 64'h13198a2e03707344;
            4'd2:    v = 64'ha4093822299f31d0;
            4'd3:    v = 64'h082efa98ec4e6c89;
            4'd4:    v = 64'h452821e638d01377;
            4'd5:    v = 64'hbe5466cf34e90c6c;
            4'd6:    v = 64'h7ef84f78fd955cb1;
            4'd7:    v = 64'h85840851f1ac43aa;
            4'd8:    v = 64'hc882d32f25323c54;
            4'd9:    v = 64'h64a51195e0e3610d;
            4'd10:   v = 64'hd3b5a399ca0c2399;
            4'd11:   v = 64'hc0ac29b7c97c50dd;
            default: v = 64'h0000000000000000;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] x, input logic inv);
        logic [63:0] tbl;
        logic [63:0] y;
        tbl = inv ? SboxInv : Sbox;
        y   = '0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = tbl[{x[4*i +: 4], 2'b00} +: 4];
        end
        return y;
    endfunction

    // Output nibble i takes input nibble tbl[i] (AES-style row shift on a 4x4 nibble grid).
    function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
        logic [63:0] tbl;
        logic [63:0] y;
        tbl = inv ? ShRowInv : ShRow;
        y   = '0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = x[{tbl[4*i +: 4], 2'b00} +: 4];
        end
        return y;
    endfunction

    // 16x16 involutive block; bit 0 of the block is its most significant bit.
    function automatic logic [15:0] m_hat(input logic [15:0] x, input int sel);
        logic [15:0] y;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                for (int c = 0; c < 4; c++) begin
                    if (((r + c + sel) % 4) != i) begin
                        y[15 - (4*r + i)] = y[15 - (4*r + i)] ^ x[15 - (4*c + i)];
                    end
                end
            end
        end
        return y;
    endfunction

    function automatic logic [63:0] mult_prime(input logic [63:0] x);
        return {m_hat(x[63:48], 0), m_hat(x[47:32], 1), m_hat(x[31:16], 1), m_hat(x[15:0], 0)};
    endfunction

    fsm_e        fsm_q, fsm_d;
    logic [2:0]  rnd_q, rnd_d;
    logic [63:0] state_q, state_d;
    logic [63:0] k0_q, k0_d, k1_q, k1_d, k0p_q, k0p_d;
    logic [63:0] data_q, data_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        clr;
    logic [63:0] key_k0, key_k1, rk_fwd, rk_bwd;
    logic [3:0]  bwd_rc_idx;

`ifdef PRIM_PRINCE_DESCR_CLEAR_EN
    assign clr = clr_i;
`else
    assign clr = 1'b0;
`endif

    assign key_k0      = key_i[127:64];
    assign key_k1      = key_i[63:0];
    assign rk_fwd      = (!UseOldKeySched && rnd_q[0]) ? k0_q : k1_q;
    assign rk_bwd      = (!UseOldKeySched && (LastRnd[0] ^ rnd_q[0] ^ 1'b1)) ? k0_q : k1_q;
    assign bwd_rc_idx  = BwdRcBase + {1'b0, rnd_q};

    assign req_ready_o = (fsm_q == ST_IDLE) && !clr;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = (fsm_q != ST_IDLE) || rsp_valid_q;
    assign fsm_state_o = fsm_q;

    // Next-state: round sequencing, key/data capture and output register load.
    always_comb begin
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        state_d     = state_q;
        k0_d        = k0_q;
        k1_d        = k1_q;
        k0p_d       = k0p_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
        unique case (fsm_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    k0_d    = key_k0;
                    k1_d    = key_k1;
                    k0p_d   = {key_k0[0], key_k0[63:2], key_k0[63] ^ key_k0[1]};
                    data_d  = req_data_i;
                    state_d = (nonce_i ^ 64'(req_addr_i)) ^ key_k0 ^ key_k1 ^ rc(4'd0);
                    rnd_d   = 3'd1;
                    fsm_d   = ST_FWD;
                end
            end
            ST_FWD: begin
                state_d = shift_rows(mult_prime(sbox64(state_q, 1'b0)), 1'b0)
                          ^ rc({1'b0, rnd_q}) ^ rk_fwd;
                rnd_d   = rnd_q + 3'd1;
                if (rnd_q == LastRnd) begin
                    fsm_d = ST_MID;
                end
            end
            ST_MID: begin
                state_d = sbox64(mult_prime(sbox64(state_q, 1'b0)), 1'b1);
                rnd_d   = 3'd1;
                fsm_d   = ST_BWD;
            end
            ST_BWD: begin
                state_d = sbox64(mult_prime(shift_rows(state_q ^ rk_bwd ^ rc(bwd_rc_idx), 1'b1)), 1'b1);
                rnd_d   = rnd_q + 3'd1;
                if (rnd_q == LastRnd) begin
                    fsm_d = ST_OUT;
                end
            end
            ST_OUT: begin
                // A result loading while the old one is taken keeps rsp_valid high.
                if (!rsp_valid_q || rsp_ready_i) begin
                    rsp_data_d  = state_q ^ rc(4'd11) ^ k1_q ^ k0p_q ^ data_q;
                    rsp_valid_d = 1'b1;
                    fsm_d       = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
        if (clr) begin
            fsm_d       = ST_IDLE;
            rnd_d       = '0;
            state_d     = '0;
            k0_d        = '0;
            k1_d        = '0;
            k0p_d       = '0;
            data_d      = '0;
            rsp_data_d  = '0;
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; async reset discards any in-flight word and pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q       <= ST_IDLE;
            rnd_q       <= '0;
            state_q     <= '0;
            k0_q        <= '0;
            k1_q        <= '0;
            k0p_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            state_q     <= state_d;
            k0_q        <= k0_d;
            k1_q        <= k1_d;
            k0p_q       <= k0p_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_prim_prince_descrambler.sv
// Directed bench for prim_prince_descrambler (NumRoundsHalf=5, UseOldKeySched=1).
// Expected data comes from published PRINCE known-answer vectors: a request whose
// data is KS ^ P must come back as P. Response latency: rsp_valid_o rises on the
// 12th rising edge after the accepting edge (13 cycles counting the accept cycle).
`timescale 1ns/1ps
module tb_prim_prince_descrambler;

    localparam logic [63:0] KS_Z  = 64'h818665aa0d02dfda; // k=0, pt=0
    localparam logic [63:0] KS_F  = 64'h604ae6ca03c20ada; // k=0, pt=all ones
    localparam logic [63:0] KS_K0 = 64'h9fb51935fc3df524; // k0=all ones, k1=0, pt=0
    localparam logic [63:0] KS_K1 = 64'h78a54cbe737bb7ef; // k0=0, k1=all ones, pt=0
    localparam logic [63:0] KS_MX = 64'hae25ad3ca8fa9ccf; // k1=fedc..3210, pt=0123..cdef

    logic         clk_i;
    logic         rst_ni;
`ifdef PRIM_PRINCE_DESCR_CLEAR_EN
    logic         clr_i;
`endif
    logic         req_valid_i;
    logic         req_ready_o;
    logic [15:0]  req_addr_i;
    logic [63:0]  req_data_i;
    logic [127:0] key_i;
    logic [63:0]  nonce_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [63:0]  rsp_data_o;
    logic         busy_o;
    logic [2:0]   fsm_state_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] pats[4];

    prim_prince_descrambler #(
        .AddrWidth     (16),
        .NumRoundsHalf (5),
        .UseOldKeySched(1'b1)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
`ifdef PRIM_PRINCE_DESCR_CLEAR_EN
        .clr_i      (clr_i),
`endif
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .key_i      (key_i),
        .nonce_i    (nonce_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o (rsp_data_o),
        .busy_o     (busy_o),
        .fsm_state_o(fsm_state_o)
    );

    // Clock and watchdog.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [127:0] key, input logic [63:0] nonce,
                             input logic [15:0] addr, input logic [63:0] data);
        key_i       = key;
        nonce_i     = nonce;
        req_addr_i  = addr;
        req_data_i  = data;
        req_valid_i = 1'b1;
    endtask

    // One transaction from IDLE with rsp_ready_i high; optionally scrambles the
    // request inputs every cycle while the word is in flight.
    task automatic run_txn(input string tag, input logic [127:0] key, input logic [63:0] nonce,
                           input logic [15:0] addr, input logic [63:0] data,
                           input logic [63:0] exp, input bit scramble);
        drive_req(key, nonce, addr, data);
        chk({tag, "_ready"}, req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (scramble) begin
                key_i      = {$urandom(), $urandom(), $urandom(), $urandom()};
                nonce_i    = {$urandom(), $urandom()};
                req_addr_i = 16'($urandom_range(0, 65535));
                req_data_i = {$urandom(), $urandom()};
            end
            tick();
        end
        chk({tag, "_early"}, {rsp_valid_o, req_ready_o}, 2'b00);
        tick();
        chk({tag, "_valid"}, rsp_valid_o, 1);
        chk({tag, "_data"}, rsp_data_o, exp);
        chk({tag, "_idle"}, req_ready_o, 1);
        tick();
        chk({tag, "_drain"}, rsp_valid_o, 0);
    endtask

    initial begin
        rst_ni      = 1'b0;
`ifdef PRIM_PRINCE_DESCR_CLEAR_EN
        clr_i       = 1'b0;
`endif
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_data_i  = '0;
        key_i       = '0;
        nonce_i     = '0;
        rsp_ready_i = 1'b0;
        pats[0] = 64'h0123456789abcdef;
        pats[1] = 64'hfedcba9876543210;
        pats[2] = 64'h5a5a5a5aa5a5a5a5;
        pats[3] = 64'h0000000100000002;

        // Reset values.
        #3;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_data", rsp_data_o, 64'h0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fsm", fsm_state_o, 3'd0);
        tick();
        tick();
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        tick();

        // Known-answer descrambles.
        run_txn("kat_zero", 128'h0, 64'h0, 16'h0, KS_Z, 64'h0, 1'b0);
        run_txn("kat_ones", 128'h0, 64'hffffffffffffffff, 16'h0, KS_F, 64'h0, 1'b0);
        run_txn("kat_ones_lsb", 128'h0, 64'hffffffffffffffff, 16'h0, KS_F ^ 64'h1, 64'h1, 1'b0);
        run_txn("kat_k0", {64'hffffffffffffffff, 64'h0}, 64'h0, 16'h0, KS_K0, 64'h0, 1'b0);
        run_txn("kat_k1", {64'h0, 64'hffffffffffffffff}, 64'h0, 16'h0, KS_K1, 64'h0, 1'b0);
        run_txn("kat_mix", {64'h0, 64'hfedcba9876543210}, 64'h0123456789ab0000, 16'hcdef,
                KS_MX ^ 64'h1122334455667788, 64'h1122334455667788, 1'b0);

        // Address folding plus key/nonce churn after accept.
        run_txn("sample", 128'h0, 64'hffffffffffff0000, 16'hffff,
                KS_F ^ 64'hdeadbeefcafef00d, 64'hdeadbeefcafef00d, 1'b1);

        // Back-to-back with req_valid_i held high.
        drive_req(128'h0, 64'h0, 16'h0, KS_Z ^ pats[0]);
        tick();
        exp_q.push_back(pats[0]);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) req_data_i = KS_Z ^ pats[i+1];
            else       req_valid_i = 1'b0;
            repeat (11) tick();
            chk("b2b_not_ready", req_ready_o, 0);
            tick();
            chk("b2b_valid", rsp_valid_o, 1);
            chk("b2b_data", rsp_data_o, exp_q.pop_front());
            chk("b2b_ready", req_ready_o, 1);
            tick();
            if (i < 3) exp_q.push_back(pats[i+1]);
            chk("b2b_reaccept", req_ready_o, (i < 3) ? 1'b0 : 1'b1);
            chk("b2b_drain", rsp_valid_o, 0);
        end

        // Backpressure: A waits 30 cycles, B stalls in OUT, C waits for a slot.
        rsp_ready_i = 1'b0;
        drive_req(128'h0, 64'h0, 16'h0, KS_Z ^ pats[1]);
        tick();
        req_data_i = KS_Z ^ pats[2];
        repeat (12) tick();
        chk("bp_a_valid", rsp_valid_o, 1);
        chk("bp_a_data", rsp_data_o, pats[1]);
        tick();
        chk("bp_b_accepted", req_ready_o, 0);
        req_data_i = KS_Z ^ pats[3];
        for (int c = 0; c < 29; c++) begin
            tick();
            chk("bp_hold_valid", rsp_valid_o, 1);
            chk("bp_hold_data", rsp_data_o, pats[1]);
        end
        chk("bp_b_in_out", fsm_state_o, 3'd4);
        chk("bp_c_blocked", req_ready_o, 0);
        chk("bp_busy", busy_o, 1);
        rsp_ready_i = 1'b1;
        tick();
        chk("bp_b_valid", rsp_valid_o, 1);
        chk("bp_b_data", rsp_data_o, pats[2]);
        chk("bp_c_ready", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        chk("bp_c_accepted", req_ready_o, 0);
        chk("bp_b_taken", rsp_valid_o, 0);
        repeat (11) tick();
        chk("bp_c_early", rsp_valid_o, 0);
        tick();
        chk("bp_c_valid", rsp_valid_o, 1);
        chk("bp_c_data", rsp_data_o, pats[3]);
        tick();

        // Async reset while a response is pending and a word is mid-flight.
        rsp_ready_i = 1'b0;
        drive_req(128'h0, 64'h0, 16'h0, KS_Z ^ pats[0]);
        tick();
        req_data_i = KS_Z ^ pats[1];
        repeat (12) tick();
        chk("ar_pending", rsp_data_o, pats[0]);
        tick();
        req_valid_i = 1'b0;
        repeat (6) tick();
        rst_ni = 1'b0;
        #1;
        chk("ar_valid", rsp_valid_o, 0);
        chk("ar_ready", req_ready_o, 1);
        chk("ar_data", rsp_data_o, 64'h0);
        chk("ar_busy", busy_o, 0);
        chk("ar_fsm", fsm_state_o, 3'd0);
        tick();
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        tick();
        run_txn("ar_recover", 128'h0, 64'h0, 16'h0, KS_Z ^ pats[2], pats[2], 1'b0);

`ifdef PRIM_PRINCE_DESCR_CLEAR_EN
        // Synchronous clear mid-round, also blocking an attempted accept.
        rsp_ready_i = 1'b0;
        drive_req(128'h0, 64'h0, 16'h0, KS_Z ^ pats[3]);
        tick();
        req_data_i = KS_Z ^ pats[0];
        repeat (12) tick();
        chk("clr_pending", rsp_data_o, pats[3]);
        tick();
        req_valid_i = 1'b0;
        repeat (6) tick();
        clr_i = 1'b1;
        #1;
        chk("clr_ready_low", req_ready_o, 0);
        tick();
        chk("clr_valid", rsp_valid_o, 0);
        chk("clr_data", rsp_data_o, 64'h0);
        chk("clr_fsm", fsm_state_o, 3'd0);
        req_valid_i = 1'b1;
        #1;
        chk("clr_block", req_ready_o, 0);
        tick();
        clr_i       = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        #1;
        chk("clr_no_accept", fsm_state_o, 3'd0);
        chk("clr_busy", busy_o, 0);
        chk("clr_ready", req_ready_o, 1);
        run_txn("clr_recover", 128'h0, 64'h0, 16'h0, KS_Z ^ pats[1], pats[1], 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
